// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_D  = 2'd2
    } arb_state_e;

    localparam int STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter; slave = arbiter, master = requesters + memory.
interface mem_port_arbiter_if #(
    parameter int MEM_DEPTH = 256
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb_starve_guard.sv
// Counts idle cycles in which fetch asks but is refused; saturates and raises fetch_prio at the limit.
module mem_arb_starve_guard #(
    parameter int STARVE_LIMIT = mem_arb_pkg::STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic in_idle,
    input  logic if_req,
    input  logic if_gnt,
    output logic fetch_prio
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (!if_req || if_gnt) begin
            count_d = '0;
        end else if (in_idle && (count_q != CW'(STARVE_LIMIT))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign fetch_prio = (count_q == CW'(STARVE_LIMIT));
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one single-ported memory; reads take two cycles, writes one.
// Optional fetch starvation guard compiled in with MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_DEPTH    = 256,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus
);
    localparam int AW = $clog2(MEM_DEPTH);

    arb_state_e state_q, state_d;
    logic       fetch_prio;
    logic       if_gnt_c;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_guard #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_guard (
        .clk        (clk),
        .reset      (reset),
        .in_idle    (state_q == IDLE),
        .if_req     (bus.if_req),
        .if_gnt     (if_gnt_c),
        .fetch_prio (fetch_prio)
    );
`else
    assign fetch_prio = 1'b0;
`endif

    // Address bits below the word and above the memory size are dropped, so accesses wrap.
    logic unused_bits;
    assign unused_bits = ^{bus.if_addr[1:0], bus.if_addr[31:2+AW],
                           bus.d_addr[1:0], bus.d_addr[31:2+AW], STARVE_LIMIT[0]};

    always_comb begin
        state_d       = state_q;
        if_gnt_c      = 1'b0;
        bus.if_gnt    = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.d_gnt     = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = '0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        // Outputs are combinational, so hold them at zero for the whole of reset.
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.d_req && !(fetch_prio && bus.if_req)) begin
                        bus.d_gnt    = 1'b1;
                        bus.mem_en   = 1'b1;
                        bus.mem_addr = bus.d_addr[2 +: AW];
                        if (bus.d_we) begin
                            bus.mem_we    = 1'b1;
                            bus.mem_wdata = bus.d_wdata;
                        end else begin
                            state_d = RD_D;
                        end
                    end else if (bus.if_req) begin
                        if_gnt_c     = 1'b1;
                        bus.if_gnt   = 1'b1;
                        bus.mem_en   = 1'b1;
                        bus.mem_addr = bus.if_addr[2 +: AW];
                        state_d      = RD_IF;
                    end
                end
                RD_IF: begin
                    bus.if_rvalid = 1'b1;
                    bus.if_rdata  = bus.mem_rdata;
                    state_d       = IDLE;
                end
                RD_D: begin
                    bus.d_rvalid = 1'b1;
                    bus.d_rdata  = bus.mem_rdata;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural one-cycle memory.
module tb_mem_port_arbiter;
    localparam int MEM_DEPTH = 256;
    localparam int AW        = $clog2(MEM_DEPTH);

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    logic [31:0] mem [MEM_DEPTH];

    mem_port_arbiter_if #(.MEM_DEPTH(MEM_DEPTH)) bus ();

    mem_port_arbiter #(
        .MEM_DEPTH    (MEM_DEPTH),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
    end

    function automatic logic [32*4+AW+6-1:0] all_outs();
        return {bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid,
                bus.d_rdata, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata};
    endfunction

    task automatic idle_inputs();
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.if_req = 1'b1;
        bus.d_req  = 1'b1;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_outs: got %h want 0", all_outs());
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL idle_outs: got %h want 0", all_outs());
        end
    endtask

    task automatic test_fetch_read();
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_000C;
        #1;
        checks++;
        if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we} !== 4'b1010 || bus.mem_addr !== 8'h03) begin
            errors++;
            $display("FAIL fetch_gnt: gnt/dgnt/en/we=%b addr=%h want 1010 addr=03",
                     {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we}, bus.mem_addr);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h2A || bus.mem_en !== 1'b0 || bus.if_gnt !== 1'b0) begin
            errors++;
            $display("FAIL fetch_rvalid: rvalid=%b rdata=%h en=%b gnt=%b want 1 2a 0 0",
                     bus.if_rvalid, bus.if_rdata, bus.mem_en, bus.if_gnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'h0) begin
            errors++;
            $display("FAIL fetch_rvalid_drop: rvalid=%b rdata=%h want 0 0", bus.if_rvalid, bus.if_rdata);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0010;
        bus.d_wdata = 32'h58;
        #1;
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 ||
            bus.mem_addr !== 8'h04 || bus.mem_wdata !== 32'h58) begin
            errors++;
            $display("FAIL data_write: gnt=%b en=%b we=%b addr=%h wdata=%h want 1 1 1 04 58",
                     bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        // A write must leave the FSM idle, so the read is granted in the very next cycle.
        @(negedge clk);
        bus.d_we    = 1'b0;
        bus.d_wdata = '0;
        #1;
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h04) begin
            errors++;
            $display("FAIL data_read_gnt: gnt=%b we=%b addr=%h want 1 0 04", bus.d_gnt, bus.mem_we, bus.mem_addr);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h58) begin
            errors++;
            $display("FAIL data_read: rvalid=%b rdata=%h want 1 58", bus.d_rvalid, bus.d_rdata);
        end
    endtask

    task automatic test_priority();
        int if_gnt_cyc;
        int both_cnt;
        if_gnt_cyc = -1;
        both_cnt   = 0;
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_000C;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h0000_0010;
        #1;
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin
            errors++;
            $display("FAIL prio_data_first: d_gnt=%b if_gnt=%b want 1 0", bus.d_gnt, bus.if_gnt);
        end
        for (int c = 0; c < 5; c++) begin
            if (c == 1) bus.d_req = 1'b0;
            #1;
            if (bus.if_gnt && bus.d_gnt) both_cnt++;
            if (bus.if_gnt && if_gnt_cyc < 0) begin
                if_gnt_cyc = c;
                bus.if_req = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (if_gnt_cyc != 2) begin
            errors++;
            $display("FAIL prio_if_gnt_cycle: got %0d want 2", if_gnt_cyc);
        end
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL prio_both_gnt: got %0d cycles want 0", both_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0040_0030;
        #1;
        checks++;
        if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 8'h0C) begin
            errors++;
            $display("FAIL wrap_addr: gnt=%b addr=%h want 1 0c", bus.if_gnt, bus.mem_addr);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL wrap_rdata: rvalid=%b rdata=%h want 1 0badf00d", bus.if_rvalid, bus.if_rdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.mem_en !== 1'b0 || bus.if_gnt !== 1'b0) begin
            errors++;
            $display("FAIL no_req_no_access: en=%b gnt=%b want 0 0", bus.mem_en, bus.if_gnt);
        end
    endtask

    task automatic test_starvation();
        int first_gnt;
        first_gnt = -1;
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_000C;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h0000_0020;
        bus.d_wdata = 32'h77;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.if_gnt === 1'b1 && first_gnt < 0) first_gnt = c;
            @(negedge clk);
        end
        idle_inputs();
`ifdef MEM_ARB_STARVE_GUARD_EN
        checks++;
        if (first_gnt != 4) begin
            errors++;
            $display("FAIL starve_guard_gnt: first if_gnt cycle %0d want 4", first_gnt);
        end
`else
        checks++;
        if (first_gnt != -1) begin
            errors++;
            $display("FAIL starve_strict_prio: first if_gnt cycle %0d want none (-1)", first_gnt);
        end
`endif
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_in_rd();
        int late_rvalid;
        late_rvalid = 0;
        @(negedge clk);
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h0000_0010;
        @(negedge clk);
        bus.d_req = 1'b0;
        #1;
        checks++;
        if (bus.d_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL rd_d_entered: d_rvalid=%b want 1", bus.d_rvalid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_in_rd_outs: got %h want 0", all_outs());
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (bus.d_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0) late_rvalid++;
            @(negedge clk);
        end
        checks++;
        if (late_rvalid != 0) begin
            errors++;
            $display("FAIL reset_no_late_rvalid: got %0d rvalid cycles want 0", late_rvalid);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = '0;
        mem[3]  = 32'h0000_002A;
        mem[12] = 32'h0BAD_F00D;
        bus.mem_rdata = '0;
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch_read();
        test_write_read();
        test_priority();
        test_wrap();
        test_starvation();
        test_reset_in_rd();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
